// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Definitions shared by the seven-segment scan decoder and the display driver.
// Segment codes are in common-anode form (0 = lit). Bit order is {a,b,c,d,e,f,g},
// so bit 6 is segment a and bit 0 is segment g.
// Contents: bcd_t nibble type, digit index constants, segment code table,
// and a BCD-to-segment encoder used by the driver side.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    // Nibble stored for a segment pattern that is not a decimal digit.
    localparam bcd_t BCD_INVALID = 4'hF;

    // Scan position of each digit within one multiplexed frame.
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [6:0] SEG_CODE_0 = 7'h01;
    localparam logic [6:0] SEG_CODE_1 = 7'h4F;
    localparam logic [6:0] SEG_CODE_2 = 7'h12;
    localparam logic [6:0] SEG_CODE_3 = 7'h06;
    localparam logic [6:0] SEG_CODE_4 = 7'h4C;
    localparam logic [6:0] SEG_CODE_5 = 7'h24;
    localparam logic [6:0] SEG_CODE_6 = 7'h20;
    localparam logic [6:0] SEG_CODE_7 = 7'h0F;
    localparam logic [6:0] SEG_CODE_8 = 7'h00;
    localparam logic [6:0] SEG_CODE_9 = 7'h04;
    localparam logic [6:0] SEG_CODE_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input bcd_t d);
        logic [6:0] code;
        case (d)
            4'd0:    code = SEG_CODE_0;
            4'd1:    code = SEG_CODE_1;
            4'd2:    code = SEG_CODE_2;
            4'd3:    code = SEG_CODE_3;
            4'd4:    code = SEG_CODE_4;
            4'd5:    code = SEG_CODE_5;
            4'd6:    code = SEG_CODE_6;
            4'd7:    code = SEG_CODE_7;
            4'd8:    code = SEG_CODE_8;
            4'd9:    code = SEG_CODE_9;
            default: code = SEG_CODE_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// -----------------------------------------------------------------------------
// seg7_to_bcd
// Pure combinational lookup from a common-anode segment pattern to a BCD digit.
// Ports:
//   code  [6:0] in   normalized segment pattern {a..g}, 0 = lit
//   digit [3:0] out  decoded digit, BCD_INVALID when the pattern is not a digit
//   valid       out  pattern matched one of the ten digit codes
// -----------------------------------------------------------------------------
module seg7_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] code,
    output bcd_t       digit,
    output logic       valid
);

    always_comb begin
        digit = BCD_INVALID;
        valid = 1'b1;
        case (code)
            SEG_CODE_0: digit = 4'd0;
            SEG_CODE_1: digit = 4'd1;
            SEG_CODE_2: digit = 4'd2;
            SEG_CODE_3: digit = 4'd3;
            SEG_CODE_4: digit = 4'd4;
            SEG_CODE_5: digit = 4'd5;
            SEG_CODE_6: digit = 4'd6;
            SEG_CODE_7: digit = 4'd7;
            SEG_CODE_8: digit = 4'd8;
            SEG_CODE_9: digit = 4'd9;
            default: begin
                digit = BCD_INVALID;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Recovers an MM:SS time from a multiplexed four-digit seven-segment display
// bus. Each digit window is sampled once after the lines have been stable for
// SETTLE_CYCLES; a frame is published when the min_tens digit is sampled after
// the three lower digits were seen.
//
// Parameters:
//   CC             1 = common-cathode lines (inverted internally), 0 = common-anode
//   SETTLE_CYCLES  stable cycles required before a window is sampled
//   TIMEOUT_CYCLES cycles without a sample before link_up drops
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   seven_seg[7:0]  in  segment lines a..g on [6:0], bit 7 ignored
//   digit_en[3:0]   in  digit enables, index 0..3 = sec_ones..min_tens
//   time_bcd[15:0]  out {min_tens, min_ones, sec_tens, sec_ones}
//   time_valid      out frame held on time_bcd/frame_err
//   time_ready      in  consumer accepts the held frame
//   frame_err       out held frame contains an error
//   overrun         out one-cycle pulse when an unaccepted frame is replaced
//   link_up         out a sample was taken within TIMEOUT_CYCLES
// Build option:
//   SEG_SCAN_RANGE_CHECK_EN  when defined, sec_tens>5 or min_tens>5 flags frame_err
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int CC             = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seven_seg,
    input  logic [3:0]  digit_en,
    output logic [15:0] time_bcd,
    output logic        time_valid,
    input  logic        time_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        link_up
);

    localparam bit INV = (CC != 0);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_FULL    = TW'(TIMEOUT_CYCLES);

    logic seg_bit7_unused;
    assign seg_bit7_unused = seven_seg[7];

    // ---------------------------------------------------------------- sync
    logic [6:0] seg_s1_q, seg_s2_q;
    logic [3:0] en_s1_q, en_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '0;
            en_s2_q  <= '0;
        end else begin
            seg_s1_q <= seven_seg[6:0];
            seg_s2_q <= seg_s1_q;
            en_s1_q  <= digit_en;
            en_s2_q  <= en_s1_q;
        end
    end

    // Internally: enable active-high, segments common-anode (0 = lit).
    logic [6:0] seg_n;
    logic [3:0] en_n;
    assign seg_n = INV ? ~seg_s2_q : seg_s2_q;
    assign en_n  = INV ? ~en_s2_q  : en_s2_q;

    // ---------------------------------------------------------------- decode
    bcd_t dec_digit;
    logic dec_valid;

    seg7_to_bcd u_dec (
        .code  (seg_n),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    logic       onehot;
    logic [1:0] idx;

    always_comb begin
        onehot = 1'b1;
        idx    = DIG_SEC_ONES;
        case (en_n)
            4'b0001: idx = DIG_SEC_ONES;
            4'b0010: idx = DIG_SEC_TENS;
            4'b0100: idx = DIG_MIN_ONES;
            4'b1000: idx = DIG_MIN_TENS;
            default: onehot = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- settle
    logic [6:0]    seg_prev_q;
    logic [3:0]    en_prev_q;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          sampled_q, sampled_d;
    logic          en_changed, changed, sample;

    assign en_changed = (en_n != en_prev_q);
    assign changed    = en_changed || (seg_n != seg_prev_q);

    // cnt_q counts consecutive unchanged comparisons; the window is taken on the
    // cycle it has reached SETTLE_CYCLES-1 with the value still unchanged.
    assign sample = !changed && onehot && !sampled_q && (cnt_q == SETTLE_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (changed)
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;

        sampled_d = sampled_q;
        if (en_changed)
            sampled_d = 1'b0;
        else if (sample)
            sampled_d = 1'b1;
    end

    // ---------------------------------------------------------------- timeout
    logic [TW-1:0] tmo_q, tmo_d;
    logic          link_q, link_d;
    logic          timeout_hit;

    assign timeout_hit = !sample && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d  = tmo_q;
        link_d = link_q;
        if (sample) begin
            tmo_d  = '0;
            link_d = 1'b1;
        end else if (timeout_hit) begin
            tmo_d  = TMO_FULL;
            link_d = 1'b0;
        end else if (tmo_q != TMO_FULL) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- shadows
    bcd_t [3:0] shadow_q, shadow_d;
    logic [3:0] mask_q, mask_d;
    logic       serr_q, serr_d;
    logic       frame_done;

    always_comb begin
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        serr_d     = serr_q;
        frame_done = 1'b0;
        if (sample) begin
            shadow_d[idx] = dec_digit;
            mask_d[idx]   = 1'b1;
            if (!dec_valid)
                serr_d = 1'b1;
            // min_tens closes the scan whether or not the frame was complete
            if (idx == DIG_MIN_TENS) begin
                frame_done = &mask_q[2:0];
                mask_d     = '0;
                serr_d     = 1'b0;
            end
        end else if (timeout_hit) begin
            // a lost link discards the partial frame, error state included
            mask_d = '0;
            serr_d = 1'b0;
        end
    end

    // The min_tens nibble comes straight from the decoder in the completing cycle.
    logic [15:0] frame_bcd;
    logic        range_err;
    logic        frame_err_calc;

    assign frame_bcd = {dec_digit, shadow_q[DIG_MIN_ONES],
                        shadow_q[DIG_SEC_TENS], shadow_q[DIG_SEC_ONES]};

`ifdef SEG_SCAN_RANGE_CHECK_EN
    assign range_err = (shadow_q[DIG_SEC_TENS] > 4'd5) || (dec_digit > 4'd5);
`else
    assign range_err = 1'b0;
`endif

    assign frame_err_calc = serr_q || !dec_valid || range_err;

    // ---------------------------------------------------------------- output
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (valid_q && time_ready)
            valid_d = 1'b0;
        if (frame_done) begin
            bcd_d   = frame_bcd;
            ferr_d  = frame_err_calc;
            valid_d = 1'b1;
            ovr_d   = valid_q && !time_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_prev_q <= '0;
            en_prev_q  <= '0;
            cnt_q      <= '0;
            sampled_q  <= 1'b0;
            tmo_q      <= '0;
            link_q     <= 1'b0;
            shadow_q   <= '0;
            mask_q     <= '0;
            serr_q     <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            seg_prev_q <= seg_n;
            en_prev_q  <= en_n;
            cnt_q      <= cnt_d;
            sampled_q  <= sampled_d;
            tmo_q      <= tmo_d;
            link_q     <= link_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            serr_q     <= serr_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign time_bcd   = bcd_q;
    assign time_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign link_up    = link_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Directed bench for seg_scan_decoder with default parameters (CC=1,
// SETTLE_CYCLES=4, TIMEOUT_CYCLES=2000). Inputs are driven in raw
// common-cathode form; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seven_seg;
    logic [3:0]  digit_en;
    logic [15:0] time_bcd;
    logic        time_valid;
    logic        time_ready;
    logic        frame_err;
    logic        overrun;
    logic        link_up;

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .seven_seg  (seven_seg),
        .digit_en   (digit_en),
        .time_bcd   (time_bcd),
        .time_valid (time_valid),
        .time_ready (time_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .link_up    (link_up)
    );

    always @(negedge clk)
        if (overrun === 1'b1) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // common-anode pattern (0 = lit) for a decimal digit
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h04;
            default: return 7'h7F;
        endcase
    endfunction

    // en_norm is active-high one-hot, code is common-anode; both inverted for CC=1
    task automatic show_raw(input logic [3:0] en_norm, input logic [6:0] code, input int cycles);
        digit_en  = ~en_norm;
        seven_seg = {1'b1, ~code};
        repeat (cycles) @(negedge clk);
    endtask

    task automatic show(input int dig, input logic [3:0] val, input int cycles);
        logic [3:0] en;
        en = 4'b0001 << dig;
        show_raw(en, seg_of(val), cycles);
    endtask

    task automatic scan(input logic [15:0] t);
        for (int i = 0; i < 4; i++) show(i, t[4*i +: 4], 20);
    endtask

    task automatic accept();
        time_ready = 1'b1;
        @(negedge clk);
        time_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        time_ready = 1'b0;
        digit_en   = 4'hF;
        seven_seg  = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_bcd",     32'(time_bcd),   32'h0);
        check("rst_valid",   32'(time_valid), 32'd0);
        check("rst_err",     32'(frame_err),  32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_link",    32'(link_up),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 12:34, three lower digits only: nothing published yet
        show(0, 4'd4, 20);
        show(1, 4'd3, 20);
        show(2, 4'd2, 20);
        check("partial_valid", 32'(time_valid), 32'd0);
        check("partial_link",  32'(link_up),    32'd1);
        show(3, 4'd1, 20);
        check("f1_valid", 32'(time_valid), 32'd1);
        check("f1_bcd",   32'(time_bcd),   32'h1234);
        check("f1_err",   32'(frame_err),  32'd0);
        accept();
        check("f1_accept_valid", 32'(time_valid), 32'd0);

        // invalid pattern on sec_tens
        show(0, 4'd4, 20);
        show_raw(4'b0010, 7'h7F, 20);
        show(2, 4'd2, 20);
        show(3, 4'd1, 20);
        check("bad_valid", 32'(time_valid), 32'd1);
        check("bad_err",   32'(frame_err),  32'd1);
        check("bad_bcd",   32'(time_bcd),   32'h12F4);
        accept();

        // clean frame clears the error
        scan(16'h1234);
        check("clean_valid", 32'(time_valid), 32'd1);
        check("clean_err",   32'(frame_err),  32'd0);
        check("clean_bcd",   32'(time_bcd),   32'h1234);
        check("no_ovr_yet",  32'(ovr_cnt),    32'd0);

        // second frame without acceptance
        scan(16'h1235);
        check("ovr_count", 32'(ovr_cnt),    32'd1);
        check("ovr_bcd",   32'(time_bcd),   32'h1235);
        check("ovr_valid", 32'(time_valid), 32'd1);
        accept();
        check("ovr_accept_valid", 32'(time_valid), 32'd0);

        // min_tens window only 2 cycles long, then enables off
        show(0, 4'd6, 20);
        show(1, 4'd3, 20);
        show(2, 4'd2, 20);
        show(3, 4'd1, 2);
        show_raw(4'b0000, 7'h7F, 20);
        check("glitch_valid", 32'(time_valid), 32'd0);
        check("glitch_ovr",   32'(ovr_cnt),    32'd1);

        // frozen with no one-hot enable
        repeat (1500) @(negedge clk);
        check("frozen_link_still_up", 32'(link_up), 32'd1);
        repeat (600) @(negedge clk);
        check("timeout_link", 32'(link_up), 32'd0);
        // timeout discarded digits 0..2, so this min_tens sample publishes nothing
        show(3, 4'd1, 20);
        check("relink",          32'(link_up),    32'd1);
        check("post_tmo_valid",  32'(time_valid), 32'd0);

        // 07:60
        scan(16'h0760);
        check("range_valid", 32'(time_valid), 32'd1);
        check("range_bcd",   32'(time_bcd),   32'h0760);
`ifdef SEG_SCAN_RANGE_CHECK_EN
        check("range_err", 32'(frame_err), 32'd1);
`else
        check("range_err", 32'(frame_err), 32'd0);
`endif
        accept();

        // two enables at once in the min_ones slot is ignored
        show(0, 4'd4, 20);
        show(1, 4'd3, 20);
        show_raw(4'b1100, seg_of(4'd2), 20);
        show(3, 4'd1, 20);
        check("multihot_valid", 32'(time_valid), 32'd0);

        // reset in the middle of a frame
        scan(16'h1234);
        check("pre_rst_valid", 32'(time_valid), 32'd1);
        show(0, 4'd5, 20);
        show(1, 4'd3, 20);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_bcd",   32'(time_bcd),   32'h0);
        check("mid_rst_valid", 32'(time_valid), 32'd0);
        check("mid_rst_err",   32'(frame_err),  32'd0);
        check("mid_rst_ovr",   32'(overrun),    32'd0);
        check("mid_rst_link",  32'(link_up),    32'd0);
        rst = 1'b0;
        show(2, 4'd2, 20);
        show(3, 4'd1, 20);
        check("post_rst_partial", 32'(time_valid), 32'd0);
        scan(16'h1235);
        check("post_rst_valid", 32'(time_valid), 32'd1);
        check("post_rst_bcd",   32'(time_bcd),   32'h1235);
        check("total_ovr",      32'(ovr_cnt),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
